hazard_scheduler: RTL and testbench
===================================

// Module: hazard_scheduler
// PURPOSE
//  Pipeline sequencer for the 5-stage RISC-V core. Consumes decoder and stage control (RegReadD/E, MemToRegE, RegWrite*, Branch/Jal/Jalr).
//  Drives per-stage Stall/Flush and EX operand forwarding selects.
//  Holds the post-reset flush sequence, the multi-cycle mul/div occupancy FSM and the stall/flush performance counters.
// PARAMETERS
//  INIT_FLUSH  4   cycles all stages flushed after reset release (>=1)
//  MD_LATENCY  8   EX occupancy of a mul/div op in cycles (>=1)
//  CNT_W       32  width of performance counters
// PORTS
//  CPU_CLK      in   1      core clock, rising edge
//  CpuRstN      in   1      reset, asynchronous, active-low
//  ICacheMiss   in   1      instruction fetch not ready this cycle
//  DCacheMiss   in   1      data access in MEM not ready this cycle
//  BranchE      in   1      branch in EX taken
//  JalrE        in   1      JALR in EX
//  JalD         in   1      JAL in ID
//  MulDivE      in   1      EX holds a mul/div op
//  Rs1D,Rs2D    in   5      ID source regs
//  Rs1E,Rs2E    in   5      EX source regs
//  RdE,RdM,RdW  in   5      destination regs per stage
//  RegReadD     in   2      [1]=rs1 used, [0]=rs2 used (ID)
//  RegReadE     in   2      same, EX
//  MemToRegE    in   1      EX instruction is a load
//  RegWriteM    in   3      MEM write mode, 0 = no write
//  RegWriteW    in   3      WB write mode, 0 = no write
//  StallF..StallW out 1 each  hold stage register (F,D,E,M,W)
//  FlushF..FlushW out 1 each  clear stage register to bubble
//  Forward1E    out  2      rs1 source: 00 reg file, 10 ResultM, 01 RegWriteDataW
//  Forward2E    out  2      rs2 source, same encoding
//  MdDoneE      out  1      mul/div result valid this cycle
//  StallCnt     out  CNT_W  cycles with StallF=1
//  FlushCnt     out  CNT_W  count of BranchE|JalrE redirects
// BEHAVIOUR
//  Reset
//   While CpuRstN=0: state=S_INIT, init_cnt=INIT_FLUSH-1, md_cnt=0, counters=0.
//   All Flush*=1, Stall*=0, Forward*=00, MdDoneE=0.
//  S_INIT
//   All Flush*=1 every cycle; init_cnt decrements each cycle.
//   On init_cnt==0, go to S_RUN next cycle (INIT_FLUSH flush cycles total).
//  Priority within S_RUN/S_MD, highest first:
//   P1 DCacheMiss: Stall F,D,E,M,W=1, no flush, md_cnt frozen, no state change.
//   P2 mul/div stall (defined below): StallF/D/E=1, FlushM=1.
//   P3 BranchE|JalrE: FlushD=1, FlushE=1; this dominates load-use.
//   P4 load-use: MemToRegE & RdE!=0 & ((RegReadD[1]&Rs1D==RdE) | (RegReadD[0]&Rs2D==RdE)).
//      Response: StallF=1, StallD=1, FlushE=1.
//   P5 JalD: FlushD=1, applied only when neither P3 nor P4 is active.
//   P6 ICacheMiss: StallF=1, FlushD=1, applied only when D is not stalled by P4.
//      When P3 is also active, it still holds F (StallF=1).
//  Mul/div FSM, with MulDivE first high in S_RUN at cycle t (no DCacheMiss):
//   MD_LATENCY=1: MdDoneE=1 in cycle t; no stall.
//   MD_LATENCY>1: stall in t; md_cnt<=MD_LATENCY-2; go to S_MD.
//   S_MD, md_cnt!=0: stall, md_cnt decrements.
//   S_MD, md_cnt==0: MdDoneE=1, no P2 stall, go to S_RUN.
//   Net effect: stall asserted t..t+L-2, MdDoneE at t+L-1.
//   A MulDivE still high in the done cycle does not restart the FSM.
//   A DCacheMiss cycle extends the sequence by exactly one cycle.
//  Forwarding (combinational; M beats W)
//   Forward1E=10 if RegReadE[1] & Rs1E!=0 & RegWriteM!=0 & RdM==Rs1E.
//   Otherwise 01 if the same test holds against W; otherwise 00. Forward2E is identical using RegReadE[0]/Rs2E.
//   x0 is never forwarded.
//  Counters
//   StallCnt += 1 on each cycle with StallF=1; FlushCnt += 1 on each cycle with BranchE|JalrE and no P1.
//   Both wrap modulo 2^CNT_W and are frozen in S_INIT.
//  Reset mid-operation aborts the mul/div sequence immediately; the FSM returns to S_INIT.
// STRUCTURE
//  Parameters.v gains: S_INIT/S_RUN/S_MD state codes; FWD_REG=2'b00, FWD_M=2'b10, FWD_W=2'b01.
//  Sub-module md_stall_seq: md_cnt plus S_MD logic.
//   Inputs: MulDivE, freeze(=DCacheMiss), run. Outputs: md_stall, MdDoneE.
//  Priority resolution and forwarding stay in the top module.
// TESTING
//  Reset release: CpuRstN 0->1 -> all Flush*=1 for exactly 4 cycles, then 0; counters=0.
//  Load-use: lw x5 in EX (MemToRegE=1, RdE=5), Rs1D=5, RegReadD=10 -> StallF=StallD=FlushE=1 for one cycle.
//  Forwarding: RdM=RdW=7, RegWriteM=RegWriteW=3, Rs1E=7 -> Forward1E=10. With RegWriteM=0 -> 01. With Rs1E=0 -> 00.
//  Mul/div, MD_LATENCY=8: MulDivE at t -> StallF/D/E=1 t..t+6, MdDoneE=1 at t+7.
//   With DCacheMiss for 2 cycles mid-op -> MdDoneE at t+9.
//  Branch vs load-use: BranchE=1 with a load-use match -> FlushD=FlushE=1, StallD=0, FlushCnt +1.
//  Wrap: preload StallCnt=2^32-1, one stall cycle -> StallCnt=0.

Source files
------------

// File: rtl/hazard_scheduler_pkg.sv
// Shared types and helpers for the pipeline hazard scheduler: state codes,
// forwarding select encodings and the EX operand forwarding rule.
package hazard_scheduler_pkg;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_MD   = 2'd2
  } sched_state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_M   = 2'b10;
  localparam logic [1:0] FWD_W   = 2'b01;

  // MEM is the younger producer, so it wins over WB; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic       used,
                                         input logic [4:0] rs,
                                         input logic [4:0] rd_m,
                                         input logic [2:0] wr_m,
                                         input logic [4:0] rd_w,
                                         input logic [2:0] wr_w);
    if (!used || rs == 5'd0) return FWD_REG;
    if (wr_m != 3'd0 && rd_m == rs) return FWD_M;
    if (wr_w != 3'd0 && rd_w == rs) return FWD_W;
    return FWD_REG;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hazard_scheduler_if.sv
// Control bundle between the pipeline (master) and the hazard scheduler (slave).
interface hazard_scheduler_if #(
  parameter int CNT_W = 32
);
  logic             ICacheMiss, DCacheMiss, BranchE, JalrE, JalD, MulDivE;
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]       RegReadD, RegReadE;
  logic             MemToRegE;
  logic [2:0]       RegWriteM, RegWriteW;
  logic             StallF, StallD, StallE, StallM, StallW;
  logic             FlushF, FlushD, FlushE, FlushM, FlushW;
  logic [1:0]       Forward1E, Forward2E;
  logic             MdDoneE;
  logic [CNT_W-1:0] StallCnt, FlushCnt;

  modport master (
    output ICacheMiss, DCacheMiss, BranchE, JalrE, JalD, MulDivE,
           Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegReadD, RegReadE,
           MemToRegE, RegWriteM, RegWriteW,
    input  StallF, StallD, StallE, StallM, StallW,
           FlushF, FlushD, FlushE, FlushM, FlushW,
           Forward1E, Forward2E, MdDoneE, StallCnt, FlushCnt
  );

  modport slave (
    input  ICacheMiss, DCacheMiss, BranchE, JalrE, JalD, MulDivE,
           Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegReadD, RegReadE,
           MemToRegE, RegWriteM, RegWriteW,
    output StallF, StallD, StallE, StallM, StallW,
           FlushF, FlushD, FlushE, FlushM, FlushW,
           Forward1E, Forward2E, MdDoneE, StallCnt, FlushCnt
  );
endinterface

// File: rtl/hazard_scheduler_md_stall_seq.sv
// Multi-cycle mul/div occupancy sequencer: stalls EX until the result is due
// and pulses md_done_o in the cycle the result is valid.
module hazard_scheduler_md_stall_seq
  import hazard_scheduler_pkg::*;
#(
  parameter int MD_LATENCY = 8
) (
  input  logic CPU_CLK,
  input  logic CpuRstN,
  input  logic run_i,
  input  logic mul_div_i,
  input  logic freeze_i,
  output logic md_stall_o,
  output logic md_done_o
);

  localparam int              RELOAD_V = (MD_LATENCY > 1) ? MD_LATENCY - 2 : 0;
  localparam int              CW       = cnt_width(RELOAD_V);
  localparam logic [CW-1:0]   RELOAD   = CW'(RELOAD_V);

  sched_state_e  md_state_q;
  logic [CW-1:0] md_cnt_q;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else tree can leave it unassigned and infer a latch.
  always_comb begin
    md_stall_o = 1'b0;
    md_done_o  = 1'b0;
    if (run_i && !freeze_i) begin
      if (md_state_q == S_MD) begin
        if (md_cnt_q == '0) md_done_o  = 1'b1;
        else                md_stall_o = 1'b1;
      end else if (mul_div_i) begin
        if (MD_LATENCY == 1) md_done_o  = 1'b1;
        else                 md_stall_o = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CPU_CLK or negedge CpuRstN) begin
    if (!CpuRstN) begin
      md_state_q <= S_RUN;
      md_cnt_q   <= '0;
    end else if (!run_i) begin
      md_state_q <= S_RUN;
      md_cnt_q   <= '0;
    end else if (!freeze_i) begin
      if (md_state_q == S_MD) begin
        if (md_cnt_q == '0) md_state_q <= S_RUN;
        else                md_cnt_q   <= md_cnt_q - CW'(1);
      end else if (mul_div_i && MD_LATENCY > 1) begin
        md_state_q <= S_MD;
        md_cnt_q   <= RELOAD;
      end
    end
  end

endmodule

// File: rtl/hazard_scheduler.sv
// Pipeline hazard scheduler for the 5-stage core: per-stage stall/flush,
// EX operand forwarding, post-reset flush sequence and perf counters.
module hazard_scheduler
  import hazard_scheduler_pkg::*;
#(
  parameter int INIT_FLUSH = 4,
  parameter int MD_LATENCY = 8,
  parameter int CNT_W      = 32
) (
  input  logic               CPU_CLK,
  input  logic               CpuRstN,
  hazard_scheduler_if.slave  bus
);

  localparam int            IW        = cnt_width(INIT_FLUSH - 1);
  localparam logic [IW-1:0] INIT_LOAD = IW'(INIT_FLUSH - 1);

  sched_state_e     state_q;
  logic [IW-1:0]    init_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic       run, redirect, load_use, md_stall, md_done;
  logic [4:0] stall, flush;  // bit 4 = F ... bit 0 = W

  assign run      = (state_q == S_RUN);
  assign redirect = bus.BranchE | bus.JalrE;
  assign load_use = bus.MemToRegE && bus.RdE != 5'd0 &&
                    ((bus.RegReadD[1] && bus.Rs1D == bus.RdE) ||
                     (bus.RegReadD[0] && bus.Rs2D == bus.RdE));

  hazard_scheduler_md_stall_seq #(.MD_LATENCY(MD_LATENCY)) u_md_stall_seq (
    .CPU_CLK    (CPU_CLK),
    .CpuRstN    (CpuRstN),
    .run_i      (run),
    .mul_div_i  (bus.MulDivE),
    .freeze_i   (bus.DCacheMiss),
    .md_stall_o (md_stall),
    .md_done_o  (md_done)
  );

  always_comb begin
    stall = '0;
    flush = '0;
    if (!run) begin
      flush = '1;
    end else if (bus.DCacheMiss) begin
      stall = '1;
    end else if (md_stall) begin
      stall = 5'b11100;
      flush = 5'b00010;
    end else begin
      if (redirect) begin
        flush[3:2] = 2'b11;
      end else if (load_use) begin
        stall[4:3] = 2'b11;
        flush[2]   = 1'b1;
      end else if (bus.JalD) begin
        flush[3] = 1'b1;
      end
      // A fetch miss is squashed into D unless D is held by a load-use bubble.
      if (bus.ICacheMiss && (redirect || !load_use)) begin
        stall[4] = 1'b1;
        flush[3] = 1'b1;
      end
    end
  end

  always_ff @(posedge CPU_CLK or negedge CpuRstN) begin
    if (!CpuRstN) begin
      state_q     <= S_INIT;
      init_cnt_q  <= INIT_LOAD;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (state_q == S_INIT) begin
      if (init_cnt_q == '0) state_q    <= S_RUN;
      else                  init_cnt_q <= init_cnt_q - IW'(1);
    end else begin
      if (stall[4])                      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (redirect && !bus.DCacheMiss)   flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign {bus.StallF, bus.StallD, bus.StallE, bus.StallM, bus.StallW} = stall;
  assign {bus.FlushF, bus.FlushD, bus.FlushE, bus.FlushM, bus.FlushW} = flush;

  assign bus.Forward1E = run ? fwd_sel(bus.RegReadE[1], bus.Rs1E, bus.RdM, bus.RegWriteM,
                                       bus.RdW, bus.RegWriteW) : FWD_REG;
  assign bus.Forward2E = run ? fwd_sel(bus.RegReadE[0], bus.Rs2E, bus.RdM, bus.RegWriteM,
                                       bus.RdW, bus.RegWriteW) : FWD_REG;
  assign bus.MdDoneE   = md_done;
  assign bus.StallCnt  = stall_cnt_q;
  assign bus.FlushCnt  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Bench for hazard_scheduler: directed table, multi-cycle sequences and a
// randomized run against a cycle-level reference model.
module tb_hazard_scheduler;

  localparam int INIT_FLUSH = 4;
  localparam int MD_LAT     = 8;

  typedef struct packed {
    logic       icm, dcm, br, jalr, jald, md;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0] rrd, rre;
    logic       m2r;
    logic [2:0] rwm, rww;
  } in_t;

  typedef struct packed {
    logic [4:0] stall;   // F,D,E,M,W
    logic [4:0] flush;
    logic [1:0] f1, f2;
    logic       done;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, rst_n2;
  in_t  in1, in2;
  out_t act1, act2;

  always #5 clk = ~clk;

  hazard_scheduler_if #(.CNT_W(32)) if1 ();
  hazard_scheduler_if #(.CNT_W(4))  if2 ();

  hazard_scheduler #(.INIT_FLUSH(INIT_FLUSH), .MD_LATENCY(MD_LAT), .CNT_W(32)) dut (
    .CPU_CLK (clk), .CpuRstN (rst_n), .bus (if1));
  hazard_scheduler #(.INIT_FLUSH(1), .MD_LATENCY(1), .CNT_W(4)) dut2 (
    .CPU_CLK (clk), .CpuRstN (rst_n2), .bus (if2));

  assign {if1.ICacheMiss, if1.DCacheMiss, if1.BranchE, if1.JalrE, if1.JalD, if1.MulDivE,
          if1.Rs1D, if1.Rs2D, if1.Rs1E, if1.Rs2E, if1.RdE, if1.RdM, if1.RdW,
          if1.RegReadD, if1.RegReadE, if1.MemToRegE, if1.RegWriteM, if1.RegWriteW} = in1;
  assign {if2.ICacheMiss, if2.DCacheMiss, if2.BranchE, if2.JalrE, if2.JalD, if2.MulDivE,
          if2.Rs1D, if2.Rs2D, if2.Rs1E, if2.Rs2E, if2.RdE, if2.RdM, if2.RdW,
          if2.RegReadD, if2.RegReadE, if2.MemToRegE, if2.RegWriteM, if2.RegWriteW} = in2;
  assign act1 = {if1.StallF, if1.StallD, if1.StallE, if1.StallM, if1.StallW,
                 if1.FlushF, if1.FlushD, if1.FlushE, if1.FlushM, if1.FlushW,
                 if1.Forward1E, if1.Forward2E, if1.MdDoneE};
  assign act2 = {if2.StallF, if2.StallD, if2.StallE, if2.StallM, if2.StallW,
                 if2.FlushF, if2.FlushD, if2.FlushE, if2.FlushM, if2.FlushW,
                 if2.Forward1E, if2.Forward2E, if2.MdDoneE};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit     in_reset;
  int     init_left;     // flush cycles still to go after reset release
  bit     md_busy;
  int     md_elapsed;    // unfrozen cycles since the mul/div op entered EX
  longint m_stall_cnt, m_flush_cnt;
  localparam longint MASK32 = 64'h0000_0000_FFFF_FFFF;

  function automatic logic [1:0] ref_fwd(input logic used, input logic [4:0] rs, input in_t x);
    if (!used || rs == 5'd0) return 2'b00;
    if (x.rwm != 3'd0 && x.rdm == rs) return 2'b10;
    if (x.rww != 3'd0 && x.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic out_t model_out(input in_t x);
    out_t o;
    logic lu, redir, lu_wins, md_stall;
    o = '0;
    if (in_reset || init_left > 0) begin
      o.flush = '1;
      return o;
    end
    o.f1 = ref_fwd(x.rre[1], x.rs1e, x);
    o.f2 = ref_fwd(x.rre[0], x.rs2e, x);
    md_stall = 1'b0;
    if (!x.dcm) begin
      if (md_busy) begin
        if (md_elapsed == MD_LAT - 1) o.done = 1'b1;
        else                          md_stall = 1'b1;
      end else if (x.md) begin
        if (MD_LAT == 1) o.done = 1'b1;
        else             md_stall = 1'b1;
      end
    end
    redir   = x.br | x.jalr;
    lu      = x.m2r && x.rde != 5'd0 &&
              ((x.rrd[1] && x.rs1d == x.rde) || (x.rrd[0] && x.rs2d == x.rde));
    lu_wins = lu && !redir;
    if (x.dcm) begin
      o.stall = '1;
    end else if (md_stall) begin
      o.stall = 5'b11100;
      o.flush = 5'b00010;
    end else begin
      o.stall[4] = lu_wins || x.icm;
      o.stall[3] = lu_wins;
      o.flush[3] = redir || (x.jald && !lu) || (x.icm && !lu_wins);
      o.flush[2] = redir || lu;
    end
    return o;
  endfunction

  task automatic model_step(input in_t x, input out_t o);
    if (in_reset) return;
    if (init_left > 0) begin
      init_left--;
      return;
    end
    m_stall_cnt = (m_stall_cnt + longint'(o.stall[4])) & MASK32;
    if ((x.br || x.jalr) && !x.dcm) m_flush_cnt = (m_flush_cnt + 1) & MASK32;
    if (!x.dcm) begin
      if (md_busy) begin
        if (md_elapsed == MD_LAT - 1) md_busy = 1'b0;
        else                          md_elapsed++;
      end else if (x.md && MD_LAT > 1) begin
        md_busy    = 1'b1;
        md_elapsed = 1;
      end
    end
  endtask

  // ---------------- cycle helpers (start/end at posedge+1) ----------------
  task automatic apply1(input in_t x);
    in1 = x;
    @(negedge clk);
  endtask

  task automatic commit1(input in_t x);
    out_t e;
    e = model_out(x);
    @(posedge clk);
    model_step(x, e);
    #1;
  endtask

  task automatic cmp_out(input string tag, input out_t a, input out_t e);
    check({tag, "_stall"}, 64'(a.stall), 64'(e.stall));
    check({tag, "_flush"}, 64'(a.flush), 64'(e.flush));
    check({tag, "_fwd1"},  64'(a.f1),    64'(e.f1));
    check({tag, "_fwd2"},  64'(a.f2),    64'(e.f2));
    check({tag, "_done"},  64'(a.done),  64'(e.done));
  endtask

  task automatic cmp_cnt(input string tag);
    check({tag, "_stallcnt"}, 64'(if1.StallCnt), m_stall_cnt);
    check({tag, "_flushcnt"}, 64'(if1.FlushCnt), m_flush_cnt);
  endtask

  task automatic model_cycle(input string tag, input in_t x);
    apply1(x);
    cmp_out(tag, act1, model_out(x));
    cmp_cnt(tag);
    commit1(x);
  endtask

  task automatic reset1();
    rst_n = 1'b0;
    in_reset = 1'b1;
    md_busy = 1'b0;
    md_elapsed = 0;
    init_left = 0;
    m_stall_cnt = 0;
    m_flush_cnt = 0;
    @(negedge clk);
    cmp_out("reset", act1, model_out(in1));
    cmp_cnt("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_reset = 1'b0;
    init_left = INIT_FLUSH;
  endtask

  function automatic vec_t mk(input string n, input in_t i, input logic [4:0] s,
                              input logic [4:0] f, input logic [1:0] a, input logic [1:0] b);
    vec_t v;
    v.name = n;
    v.i    = i;
    v.o    = {s, f, a, b, 1'b0};
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl[$];
    in_t   x, lu;
    longint exp_fc;

    // Directed table: every entry applied in S_RUN with no mul/div in flight.
    x = '0;
    tbl.push_back(mk("idle", x, 5'b00000, 5'b00000, 2'b00, 2'b00));
    lu = '0; lu.m2r = 1; lu.rde = 5; lu.rs1d = 5; lu.rrd = 2'b10;
    tbl.push_back(mk("load_use_rs1", lu, 5'b11000, 5'b00100, 2'b00, 2'b00));
    x = '0; x.m2r = 1; x.rde = 5; x.rs2d = 5; x.rrd = 2'b01;
    tbl.push_back(mk("load_use_rs2", x, 5'b11000, 5'b00100, 2'b00, 2'b00));
    x = lu; x.rde = 0; x.rs1d = 0;
    tbl.push_back(mk("load_use_x0", x, 5'b00000, 5'b00000, 2'b00, 2'b00));
    x = lu; x.rrd = 2'b00;
    tbl.push_back(mk("load_use_unused", x, 5'b00000, 5'b00000, 2'b00, 2'b00));
    x = lu; x.br = 1;
    tbl.push_back(mk("branch_vs_lu", x, 5'b00000, 5'b01100, 2'b00, 2'b00));
    x = '0; x.jalr = 1;
    tbl.push_back(mk("jalr", x, 5'b00000, 5'b01100, 2'b00, 2'b00));
    x = '0; x.jald = 1;
    tbl.push_back(mk("jald", x, 5'b00000, 5'b01000, 2'b00, 2'b00));
    x = lu; x.jald = 1;
    tbl.push_back(mk("jald_vs_lu", x, 5'b11000, 5'b00100, 2'b00, 2'b00));
    x = '0; x.icm = 1;
    tbl.push_back(mk("icache_miss", x, 5'b10000, 5'b01000, 2'b00, 2'b00));
    x = lu; x.icm = 1;
    tbl.push_back(mk("icache_lu", x, 5'b11000, 5'b00100, 2'b00, 2'b00));
    x = '0; x.icm = 1; x.br = 1;
    tbl.push_back(mk("icache_branch", x, 5'b10000, 5'b01100, 2'b00, 2'b00));
    x = lu; x.icm = 1; x.br = 1; x.dcm = 1;
    tbl.push_back(mk("dcache_all", x, 5'b11111, 5'b00000, 2'b00, 2'b00));
    x = '0; x.rdm = 7; x.rdw = 7; x.rwm = 3; x.rww = 3; x.rs1e = 7; x.rre = 2'b10;
    tbl.push_back(mk("fwd_m", x, 5'b00000, 5'b00000, 2'b10, 2'b00));
    x.rwm = 0;
    tbl.push_back(mk("fwd_w", x, 5'b00000, 5'b00000, 2'b01, 2'b00));
    x.rwm = 3; x.rs1e = 0; x.rdm = 0; x.rdw = 0;
    tbl.push_back(mk("fwd_x0", x, 5'b00000, 5'b00000, 2'b00, 2'b00));
    x = '0; x.rre = 2'b01; x.rs1e = 9; x.rs2e = 9; x.rdm = 9; x.rwm = 0; x.rdw = 9; x.rww = 1;
    tbl.push_back(mk("fwd2_w", x, 5'b00000, 5'b00000, 2'b00, 2'b01));
    x = '0; x.rre = 2'b11; x.rs1e = 3; x.rs2e = 3; x.rdm = 3; x.rwm = 2; x.rdw = 3; x.rww = 2;
    tbl.push_back(mk("fwd_both_m", x, 5'b00000, 5'b00000, 2'b10, 2'b10));

    in1 = '0; in2 = '0;
    rst_n = 1'b0; rst_n2 = 1'b0;
    @(posedge clk);
    #1;

    // Reset with a matching forwarding pattern on the inputs: still 00.
    in1 = tbl[13].i;
    reset1();

    // Release: exactly INIT_FLUSH all-flush cycles, counters stay zero.
    for (int k = 0; k < INIT_FLUSH + 2; k++) begin
      apply1('0);
      check($sformatf("init_flush_c%0d", k), 64'(act1.flush), (k < INIT_FLUSH) ? 64'h1f : 64'h0);
      check($sformatf("init_stall_c%0d", k), 64'(act1.stall), 64'h0);
      commit1('0);
    end
    check("init_stallcnt", 64'(if1.StallCnt), 64'h0);
    check("init_flushcnt", 64'(if1.FlushCnt), 64'h0);

    foreach (tbl[v]) begin
      apply1(tbl[v].i);
      cmp_out(tbl[v].name, act1, tbl[v].o);
      cmp_cnt(tbl[v].name);
      commit1(tbl[v].i);
    end

    // Branch beats load-use and counts one redirect.
    exp_fc = m_flush_cnt + 1;
    x = lu; x.br = 1;
    apply1(x);
    check("br_lu_stalld", 64'(act1.stall[3]), 64'h0);
    commit1(x);
    apply1('0);
    check("br_lu_flushcnt", 64'(if1.FlushCnt), exp_fc);
    commit1('0);

    // Mul/div, 8-cycle occupancy: stall t..t+6, done at t+7.
    x = '0; x.md = 1;
    for (int k = 0; k < MD_LAT; k++) begin
      apply1(x);
      check($sformatf("md_stall_t%0d", k), 64'(act1.stall), (k < MD_LAT - 1) ? 64'h1c : 64'h0);
      check($sformatf("md_flush_t%0d", k), 64'(act1.flush), (k < MD_LAT - 1) ? 64'h02 : 64'h0);
      check($sformatf("md_done_t%0d", k),  64'(act1.done),  (k == MD_LAT - 1) ? 64'h1 : 64'h0);
      commit1(x);
    end
    apply1('0);
    check("md_after_stall", 64'(act1.stall), 64'h0);
    check("md_after_done",  64'(act1.done),  64'h0);
    commit1('0);

    // Same op with two DCacheMiss cycles mid-flight: done moves to t+9.
    for (int k = 0; k < MD_LAT + 2; k++) begin
      x = '0; x.md = 1; x.dcm = (k == 3 || k == 4);
      apply1(x);
      check($sformatf("mdd_stall_t%0d", k), 64'(act1.stall),
            (k == MD_LAT + 1) ? 64'h0 : (x.dcm ? 64'h1f : 64'h1c));
      check($sformatf("mdd_done_t%0d", k), 64'(act1.done), (k == MD_LAT + 1) ? 64'h1 : 64'h0);
      commit1(x);
    end

    // Reset in the middle of a mul/div op aborts it.
    x = '0; x.md = 1;
    for (int k = 0; k < 3; k++) model_cycle($sformatf("mdrst_pre%0d", k), x);
    reset1();
    for (int k = 0; k < INIT_FLUSH + 2; k++) model_cycle($sformatf("mdrst_post%0d", k), '0);

    // Randomized run against the reference model.
    for (int n = 0; n < 3000; n++) begin
      x = '0;
      x.icm  = ($urandom_range(0, 3) == 0);
      x.dcm  = ($urandom_range(0, 7) == 0);
      x.br   = ($urandom_range(0, 7) == 0);
      x.jalr = ($urandom_range(0, 15) == 0);
      x.jald = ($urandom_range(0, 7) == 0);
      x.md   = ($urandom_range(0, 5) == 0);
      x.rs1d = 5'($urandom_range(0, 3));
      x.rs2d = 5'($urandom_range(0, 3));
      x.rs1e = 5'($urandom_range(0, 3));
      x.rs2e = 5'($urandom_range(0, 3));
      x.rde  = 5'($urandom_range(0, 3));
      x.rdm  = 5'($urandom_range(0, 3));
      x.rdw  = 5'($urandom_range(0, 3));
      x.rrd  = 2'($urandom_range(0, 3));
      x.rre  = 2'($urandom_range(0, 3));
      x.m2r  = 1'($urandom_range(0, 1));
      x.rwm  = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      x.rww  = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      model_cycle($sformatf("rnd%0d", n), x);
    end

    // Second instance: INIT_FLUSH=1, MD_LATENCY=1, 4-bit counters.
    @(posedge clk);
    #1;
    rst_n2 = 1'b1;
    @(negedge clk);
    check("d2_init_flush", 64'(act2.flush), 64'h1f);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("d2_run_flush", 64'(act2.flush), 64'h0);
    @(posedge clk);
    #1;
    in2.md = 1'b1;
    @(negedge clk);
    check("d2_md1_done",  64'(act2.done),  64'h1);
    check("d2_md1_stall", 64'(act2.stall), 64'h0);
    @(posedge clk);
    #1;
    in2 = '0;
    in2.icm = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      check($sformatf("d2_stallcnt_%0d", k), 64'(if2.StallCnt), 64'(k % 16));
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
